// File: rtl/microcode_pkg.sv
// Shared definitions for the boot-time microcode loader and the core's microcode store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package microcode_pkg;

  // Default store geometry, shared with the core's writable microcode store
  localparam int MC_WORD_W = 19;
  localparam int MC_DEPTH  = 39;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/microcode_loader.sv
// Streams a DEPTH-word image into the microcode store, holding the core in reset until loaded.
// Latency: accepted beat -> store write 1 cycle; last write -> core released 1 cycle later.
// Backpressure: s_ready_o high only while loading/checking; optional MICROCODE_LOADER_CHECKSUM_EN adds a sum beat.
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int WORD_W = MC_WORD_W,
  parameter int DEPTH  = MC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              mc_we_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  output logic [WORD_W-1:0] mc_data_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                s_ready_q, s_ready_d;
  logic                mc_we_q, mc_we_d;
  logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
  logic [WORD_W-1:0]   mc_data_q, mc_data_d;
  logic                core_rst_q, core_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic                error_q, error_d;
`endif

  logic xfer;
  assign xfer = s_valid_i && s_ready_q;

  // Next-state, write-port and status computation; every output is a registered copy of these
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_we_d   = 1'b0;
    mc_addr_d = mc_addr_q;
    mc_data_d = mc_data_q;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // Entering LOAD (first load or reload) always restarts at address 0
        if (start_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          mc_we_d   = 1'b1;
          mc_addr_d = cnt_q;
          mc_data_d = s_data_i;
          cnt_d     = cnt_q + 1'b1;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
          sum_d     = sum_q + s_data_i;
          if (cnt_q == LAST_ADDR) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_ADDR) state_d = ST_DONE;
`endif
        end
      end
      ST_CHECK: begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        // The sum beat is only compared, never written to the store
        if (xfer) state_d = (s_data_i == sum_q) ? ST_DONE : ST_ERROR;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d  = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    busy_d     = s_ready_d;
    // Straight from LOAD the final write is still in flight, so release the core one cycle later
    done_d     = (state_d == ST_DONE) && (state_q != ST_LOAD);
    core_rst_d = !done_d;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    error_d    = (state_d == ST_ERROR);
`endif
  end

  // State and output registers with synchronous reset; store contents are left as they are
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      mc_we_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_data_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      mc_we_q    <= mc_we_d;
      mc_addr_q  <= mc_addr_d;
      mc_data_q  <= mc_data_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      error_q    <= error_d;
`endif
    end
  end

  assign s_ready_o  = s_ready_q;
  assign mc_we_o    = mc_we_q;
  assign mc_addr_o  = mc_addr_q;
  assign mc_data_o  = mc_data_q;
  assign core_rst_o = core_rst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  assign error_o    = error_q;
`else
  assign error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_loader.sv
// Directed bench for microcode_loader: per-cycle vector table plus multi-cycle load sequences.
// Latency: checks store writes one cycle after each accepted beat and core release after the last write.
// Backpressure: drives beats only counting them when s_ready_o was high; all waits are cycle-bounded.
module tb_microcode_loader;

  localparam int WORD_W = 19;
  localparam int DEPTH  = 39;
  localparam int ADDR_W = 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [WORD_W-1:0] s_data_i;
  logic              mc_we_o;
  logic [ADDR_W-1:0] mc_addr_o;
  logic [WORD_W-1:0] mc_data_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  microcode_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .mc_we_o(mc_we_o), .mc_addr_o(mc_addr_o), .mc_data_o(mc_data_o),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [WORD_W-1:0] wq_data[$];

  // Log every store write, sampled away from the active edge
  always @(negedge clk_i) begin
    if (mc_we_o) begin
      wq_addr.push_back(mc_addr_o);
      wq_data.push_back(mc_data_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("start_ready", 32'(s_ready_o), 32'd1);
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_core_rst", 32'(core_rst_o), 32'd1);
    check("start_done_clr", 32'(done_o), 32'd0);
  endtask

  // Send n beats of data mul*i; optionally toggle valid and pulse start mid-load
  task automatic send_words(input int n, input int mul, input bit throttle, input int start_at);
    int  i;
    int  cyc;
    bit  tog;
    bit  x;
    i = 0; cyc = 0; tog = 1'b1;
    while (i < n && cyc < 1000) begin
      s_valid_i = throttle ? tog : 1'b1;
      tog       = !tog;
      s_data_i  = WORD_W'(mul * i);
      start_i   = (cyc == start_at);
      x         = s_valid_i && s_ready_o;
      step();
      if (x) i++;
      cyc++;
    end
    s_valid_i = 1'b0;
    start_i   = 1'b0;
    if (cyc >= 1000) check("send_timeout", 32'(i), 32'(n));
  endtask

  // Called at the sample point right after the last data beat's edge
  task automatic finish_image(input logic [WORD_W-1:0] sum, input bit corrupt);
    check("last_we", 32'(mc_we_o), 32'd1);
    check("last_addr", 32'(mc_addr_o), 32'(DEPTH - 1));
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    check("ck_ready", 32'(s_ready_o), 32'd1);
    check("ck_not_done", 32'(done_o), 32'd0);
    s_valid_i = 1'b1;
    s_data_i  = corrupt ? sum + 1'b1 : sum;
    step();
    s_valid_i = 1'b0;
    check("ck_no_write", 32'(mc_we_o), 32'd0);
    check("ck_done", 32'(done_o), 32'(!corrupt));
    check("ck_error", 32'(error_o), 32'(corrupt));
    check("ck_core_rst", 32'(core_rst_o), 32'(corrupt));
    check("ck_ready_drop", 32'(s_ready_o), 32'd0);
    if (corrupt) begin
      repeat (5) step();
      check("err_hold_rst", 32'(core_rst_o), 32'd1);
      check("err_hold", 32'(error_o), 32'd1);
    end
`else
    check("n1_ready_drop", 32'(s_ready_o), 32'd0);
    check("n1_not_done", 32'(done_o), 32'd0);
    check("n1_core_rst", 32'(core_rst_o), 32'd1);
    step();
    check("n2_done", 32'(done_o), 32'd1);
    check("n2_core_rst", 32'(core_rst_o), 32'd0);
    check("n2_busy", 32'(busy_o), 32'd0);
    check("n2_no_we", 32'(mc_we_o), 32'd0);
    check("n2_error", 32'(error_o), 32'd0);
`endif
  endtask

  task automatic check_writes(input int mul);
    check("wr_count", 32'(wq_addr.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < wq_addr.size(); i++) begin
      check("wr_addr", 32'(wq_addr[i]), 32'(i));
      check("wr_data", 32'(wq_data[i]), 32'(WORD_W'(mul * i)));
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  function automatic logic [WORD_W-1:0] img_sum(input int mul);
    logic [WORD_W-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + WORD_W'(mul * i);
    return s;
  endfunction

  typedef struct {
    logic              rst;
    logic              start;
    logic              valid;
    logic [WORD_W-1:0] data;
    logic              e_ready;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [WORD_W-1:0] e_data;
    logic              e_core_rst;
    logic              e_busy;
    logic              e_done;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;

    //          rst   start valid data        rdy   we    addr  data        crst  busy  done
    vecs[0] = '{1'b1, 1'b0, 1'b0, 19'h0,      1'b0, 1'b0, 6'd0, 19'h0,      1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 19'h0,      1'b0, 1'b0, 6'd0, 19'h0,      1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 19'h5,      1'b0, 1'b0, 6'd0, 19'h0,      1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 19'h0,      1'b1, 1'b0, 6'd0, 19'h0,      1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 19'h7,      1'b1, 1'b1, 6'd0, 19'h7,      1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 19'h3,      1'b1, 1'b0, 6'd0, 19'h0,      1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 19'h7FFFF,  1'b1, 1'b1, 6'd1, 19'h7FFFF,  1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 19'h11,     1'b0, 1'b0, 6'd0, 19'h0,      1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 19'h22,     1'b0, 1'b0, 6'd0, 19'h0,      1'b1, 1'b0, 1'b0};

    for (int v = 0; v < 9; v++) begin
      rst_i = vecs[v].rst; start_i = vecs[v].start;
      s_valid_i = vecs[v].valid; s_data_i = vecs[v].data;
      step();
      check($sformatf("v%0d_ready", v), 32'(s_ready_o), 32'(vecs[v].e_ready));
      check($sformatf("v%0d_we", v), 32'(mc_we_o), 32'(vecs[v].e_we));
      if (vecs[v].e_we || vecs[v].rst) begin
        check($sformatf("v%0d_addr", v), 32'(mc_addr_o), 32'(vecs[v].e_addr));
        check($sformatf("v%0d_data", v), 32'(mc_data_o), 32'(vecs[v].e_data));
      end
      check($sformatf("v%0d_core_rst", v), 32'(core_rst_o), 32'(vecs[v].e_core_rst));
      check($sformatf("v%0d_busy", v), 32'(busy_o), 32'(vecs[v].e_busy));
      check($sformatf("v%0d_done", v), 32'(done_o), 32'(vecs[v].e_done));
      check($sformatf("v%0d_error", v), 32'(error_o), 32'd0);
    end
    rst_i = 1'b0; start_i = 1'b0; s_valid_i = 1'b0;
    step();
    wq_addr.delete();
    wq_data.delete();

    // Back-to-back image, data = 3*i
    pulse_start();
    send_words(DEPTH, 3, 1'b0, -1);
    finish_image(img_sum(3), 1'b0);
    check_writes(3);

    // Reload from DONE with a throttled stream and an ignored mid-load start
    pulse_start();
    send_words(DEPTH, 7, 1'b1, 20);
    finish_image(img_sum(7), 1'b0);
    check_writes(7);

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    // Corrupted sum beat lands in ERROR and keeps the core in reset
    pulse_start();
    send_words(DEPTH, 5, 1'b0, -1);
    finish_image(img_sum(5), 1'b1);
    check_writes(5);
`endif

    // Mid-load reset after beat 10, then a fresh load starts at address 0
    pulse_start();
    send_words(11, 9, 1'b0, -1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mrst_we", 32'(mc_we_o), 32'd0);
    check("mrst_ready", 32'(s_ready_o), 32'd0);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_core_rst", 32'(core_rst_o), 32'd1);
    check("mrst_partial_writes", 32'(wq_addr.size()), 32'd11);
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_words(DEPTH, 5, 1'b0, -1);
    finish_image(img_sum(5), 1'b0);
    check_writes(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/microcode_loader.md
# microcode_loader

Boot-time loader that streams a microcode image into the core's writable microcode store and holds the core in reset until the image is complete. It sits between a boot source (ROM reader, UART, or debug port) and the core's `microcode_we_i` / `microcode_write_addr_i` / `microcode_write_data_i` port. It replaces hand-sequenced microcode writes with a valid/ready stream, generalised in word width and store depth. It also supports reload and optional image checksum verification.

## Interface
- `WORD_W`, 19, microcode word width in bits
- `DEPTH`, 39, number of microcode entries to load; must be at least 2
- `ADDR_W`, `$clog2(DEPTH)`, write address width (6 at defaults)
- `clk_i`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous active-high reset
- `start_i`  in  1  single-cycle request to begin a load
- `s_valid_i`  in  1  stream beat valid
- `s_ready_o`  out  1  loader accepts a beat
- `s_data_i`  in  WORD_W  stream beat: microcode word, or checksum word
- `mc_we_o`  out  1  microcode store write enable
- `mc_addr_o`  out  ADDR_W  microcode store write address
- `mc_data_o`  out  WORD_W  microcode store write data
- `core_rst_o`  out  1  core reset; high except in DONE
- `busy_o`  out  1  high in LOAD or CHECK
- `done_o`  out  1  high in DONE
- `error_o`  out  1  high in ERROR

## Operation
- States and transitions:
  - IDLE: `start_i` moves to LOAD.
  - LOAD: accepting the word for address `DEPTH-1` moves to CHECK when `MICROCODE_LOADER_CHECKSUM_EN` is defined, otherwise to DONE.
  - CHECK: accepting one beat moves to DONE on match, or to ERROR on mismatch.
  - DONE and ERROR: `start_i` moves to LOAD (reload).
- Entering LOAD clears the address counter and the checksum accumulator to 0.
- A beat transfers when `s_valid_i && s_ready_o`. `s_ready_o` = 1 only in LOAD and CHECK. Data is sampled only on a transfer.
- Each LOAD transfer produces exactly one `mc_we_o` pulse, carrying the current counter value and `s_data_i`. The counter then increments. Addresses are always contiguous 0..DEPTH-1 regardless of gaps in `s_valid_i`.
- Checksum: sum of all DEPTH data words mod 2^WORD_W. The CHECK beat is compared against this sum; it is never written to the store.
- `start_i` is ignored in LOAD and CHECK.
- `rst_i` at any time, including mid-load, returns to IDLE with all outputs at their reset values. Partially written store contents are not cleared.
- Reset values: `s_ready_o`=0, `mc_we_o`=0, `mc_addr_o`=0, `mc_data_o`=0, `core_rst_o`=1, `busy_o`=0, `done_o`=0, `error_o`=0.

## Timing
- All outputs are registered.
- A beat accepted at cycle N gives `mc_we_o`=1 with its address and data at N+1. Sustained throughput is one word per cycle. `mc_we_o` is high for exactly one cycle per beat.
- `start_i` at cycle N: state is LOAD and `s_ready_o`=1 at N+1. `core_rst_o` rises at N+1 when restarting from DONE.
- Without checksum: last word accepted at N, its write pulse at N+1, and `done_o`=1 / `core_rst_o`=0 at N+2. The core is therefore never released before its final store write lands.
- With checksum: checksum beat accepted at M gives `done_o` or `error_o` at M+1. `s_ready_o`=0 from M+1.
- In ERROR, `core_rst_o` stays 1 indefinitely until `start_i` or `rst_i`.

## Configuration
- `MICROCODE_LOADER_CHECKSUM_EN` defined: the CHECK state, checksum accumulator and ERROR reachability are compiled in, and the stream carries DEPTH+1 beats.
- Macro not defined: no accumulator and no CHECK state, and the stream carries exactly DEPTH beats. `error_o` is tied to 0.

## Structure
- `microcode_pkg`: loader state enum (IDLE, LOAD, CHECK, DONE, ERROR) and default `WORD_W` / `DEPTH` constants shared with the core's microcode store.
- Single module, no sub-module. The FSM, address counter and accumulator are small enough to remain inline.

## Test plan
- Reset: hold `rst_i`=1 for 2 cycles → `core_rst_o`=1, `s_ready_o`=0, `mc_we_o`=0, `busy_o`=`done_o`=`error_o`=0.
- Back-to-back load: `start_i`, then 39 beats with data = 3*i → 39 single-cycle writes at addresses 0..38 with data 3*i. `done_o`=1 and `core_rst_o`=0 2 cycles after the last beat (no checksum).
- Throttled stream: `s_valid_i` toggling every cycle, with `start_i` pulsed mid-load → writes still contiguous 0..38, no duplicate writes, `start_i` ignored.
- Checksum (macro defined): correct sum beat → `done_o`=1 at M+1. The same sum +1 → `error_o`=1, `core_rst_o` held 1, no write for the checksum beat.
- Mid-load reset: `rst_i` pulsed after beat 10 → IDLE next cycle, `mc_we_o`=0. A subsequent `start_i` writes from address 0.
- Reload: `start_i` in DONE → `core_rst_o`=1 next cycle, a fresh 39-word image is written, `done_o` is reasserted.
